spmv_mem_req_arbiter: RTL and testbench

//  Per-PE memory request scheduler. Shares the single PE memory port between three requester queues:
//  MAC result stores, x-vector cache loads and matrix-decoder loads. Generates the store address

---
 rtl/spmv_mem_req_arbiter.sv | 141 ++++++++++++++
 tb/tb_spmv_mem_req_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_mem_req_arbiter.sv
// Per-PE memory request scheduler: shares one memory port between store, x-cache and decoder queues.
// Optional starvation guard for the two load queues is enabled by defining SPMV_ARB_FAIRNESS_EN.
module spmv_mem_req_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  input  logic [63:0] st_data,
  output logic        st_pop,
  input  logic        ldx_valid,
  input  logic [47:0] ldx_addr,
  output logic        ldx_pop,
  input  logic        ldm_valid,
  input  logic [47:0] ldm_addr,
  input  logic [1:0]  ldm_tag,
  output logic        ldm_pop,
  input  logic        cfg_wr,
  input  logic [47:0] cfg_st_base,
  input  logic [47:0] cfg_st_end,
  output logic        req_mem_ld,
  output logic        req_mem_st,
  output logic [47:0] req_mem_addr,
  output logic [63:0] req_mem_d_or_tag,
  input  logic        req_mem_stall,
  output logic [47:0] st_addr_q,
  output logic        st_window_done,
  output logic        busy
);

  logic        r_ld;
  logic        r_st;
  logic [47:0] r_addr;
  logic [63:0] r_d_or_tag;
  logic [47:0] r_st_addr;
  logic [47:0] r_st_end;

  logic w_arb_en;
  logic w_window_done;
  logic w_gnt_st;
  logic w_gnt_x;
  logic w_gnt_m;

  // Pops are held low during reset so upstream queues never drain while being cleared.
  assign w_arb_en      = !rst && !req_mem_stall;
  assign w_window_done = (r_st_addr == r_st_end);

`ifdef SPMV_ARB_FAIRNESS_EN
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt_x;
  logic [CNT_W-1:0] r_cnt_m;
  logic             w_starve_x;
  logic             w_starve_m;

  assign w_starve_x = (r_cnt_x == LIMIT);
  assign w_starve_m = (r_cnt_m == LIMIT);
`endif

  // NOTE: every output of a combinational block gets a default first, otherwise paths that skip
  // an assignment infer a latch.
  always_comb begin
    w_gnt_st = 1'b0;
    w_gnt_x  = 1'b0;
    w_gnt_m  = 1'b0;
    if (w_arb_en) begin
`ifdef SPMV_ARB_FAIRNESS_EN
      if (ldx_valid && w_starve_x)      w_gnt_x = 1'b1;
      else if (ldm_valid && w_starve_m) w_gnt_m = 1'b1;
      else
`endif
      if (st_valid)       w_gnt_st = 1'b1;
      else if (ldx_valid) w_gnt_x  = 1'b1;
      else if (ldm_valid) w_gnt_m  = 1'b1;
    end
  end

`ifdef SPMV_ARB_FAIRNESS_EN
  // Counters saturate at the limit so a stalled starved queue keeps its claim.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_x <= '0;
      r_cnt_m <= '0;
    end else begin
      if (!ldx_valid || w_gnt_x)                       r_cnt_x <= '0;
      else if ((w_gnt_st || w_gnt_m) && !w_starve_x)   r_cnt_x <= r_cnt_x + 1'b1;
      if (!ldm_valid || w_gnt_m)                       r_cnt_m <= '0;
      else if ((w_gnt_st || w_gnt_x) && !w_starve_m)   r_cnt_m <= r_cnt_m + 1'b1;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld       <= 1'b0;
      r_st       <= 1'b0;
      r_addr     <= '0;
      r_d_or_tag <= '0;
    end else begin
      r_ld <= w_gnt_x | w_gnt_m;
      r_st <= w_gnt_st & ~w_window_done;
      if (w_gnt_st && !w_window_done) begin
        r_addr     <= r_st_addr;
        r_d_or_tag <= st_data;
      end else if (w_gnt_x) begin
        r_addr     <= ldx_addr;
        r_d_or_tag <= 64'h1;
      end else if (w_gnt_m) begin
        r_addr     <= ldm_addr;
        r_d_or_tag <= {61'b0, ldm_tag, 1'b0};
      end
    end
  end

  // A config write overrides the post-store increment taken in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st_addr <= '0;
      r_st_end  <= '0;
    end else if (cfg_wr) begin
      r_st_addr <= cfg_st_base;
      r_st_end  <= cfg_st_end;
    end else if (w_gnt_st && !w_window_done) begin
      r_st_addr <= r_st_addr + 48'd8;
    end
  end

  assign st_pop           = w_gnt_st;
  assign ldx_pop          = w_gnt_x;
  assign ldm_pop          = w_gnt_m;
  assign req_mem_ld       = r_ld;
  assign req_mem_st       = r_st;
  assign req_mem_addr     = r_addr;
  assign req_mem_d_or_tag = r_d_or_tag;
  assign st_addr_q        = r_st_addr;
  assign st_window_done   = w_window_done;
  assign busy             = st_valid | ldx_valid | ldm_valid | r_ld | r_st;

endmodule

// File: tb/tb_spmv_mem_req_arbiter.sv
// Directed bench for spmv_mem_req_arbiter: vector table for single-cycle arbitration plus
// hand-written sequences for store window, ordering, stall, fairness, cfg collision and async reset.
module tb_spmv_mem_req_arbiter;

  logic        clk;
  logic        rst;
  logic        st_valid;
  logic [63:0] st_data;
  logic        st_pop;
  logic        ldx_valid;
  logic [47:0] ldx_addr;
  logic        ldx_pop;
  logic        ldm_valid;
  logic [47:0] ldm_addr;
  logic [1:0]  ldm_tag;
  logic        ldm_pop;
  logic        cfg_wr;
  logic [47:0] cfg_st_base;
  logic [47:0] cfg_st_end;
  logic        req_mem_ld;
  logic        req_mem_st;
  logic [47:0] req_mem_addr;
  logic [63:0] req_mem_d_or_tag;
  logic        req_mem_stall;
  logic [47:0] st_addr_q;
  logic        st_window_done;
  logic        busy;

  int checks = 0;
  int errors = 0;

  spmv_mem_req_arbiter #(.STARVE_LIMIT(8), .CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .st_valid         (st_valid),
    .st_data          (st_data),
    .st_pop           (st_pop),
    .ldx_valid        (ldx_valid),
    .ldx_addr         (ldx_addr),
    .ldx_pop          (ldx_pop),
    .ldm_valid        (ldm_valid),
    .ldm_addr         (ldm_addr),
    .ldm_tag          (ldm_tag),
    .ldm_pop          (ldm_pop),
    .cfg_wr           (cfg_wr),
    .cfg_st_base      (cfg_st_base),
    .cfg_st_end       (cfg_st_end),
    .req_mem_ld       (req_mem_ld),
    .req_mem_st       (req_mem_st),
    .req_mem_addr     (req_mem_addr),
    .req_mem_d_or_tag (req_mem_d_or_tag),
    .req_mem_stall    (req_mem_stall),
    .st_addr_q        (st_addr_q),
    .st_window_done   (st_window_done),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s, x, m, stall;
    logic [1:0]  tag;
    logic [63:0] d;
    logic [2:0]  pop;   // {st, ldx, ldm}
    logic        ld, st;
    logic [47:0] addr;
    logic [63:0] dt;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic x, input logic m, input logic stall,
                       input logic [1:0] tag, input logic [63:0] d);
    st_valid      = s;
    ldx_valid     = x;
    ldm_valid     = m;
    req_mem_stall = stall;
    ldm_tag       = tag;
    st_data       = d;
  endtask

  // Checks the combinational pops mid-cycle, then advances to just after the next edge.
  task automatic tick_pop(input string name, input logic [2:0] exp_pop);
    @(negedge clk);
    check(name, {61'b0, st_pop, ldx_pop, ldm_pop}, {61'b0, exp_pop});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_req(input string name, input logic ld, input logic st,
                         input logic [47:0] addr, input logic [63:0] dt);
    check({name, "_ld"}, {63'b0, req_mem_ld}, {63'b0, ld});
    check({name, "_st"}, {63'b0, req_mem_st}, {63'b0, st});
    if (ld || st) begin
      check({name, "_addr"}, {16'b0, req_mem_addr}, {16'b0, addr});
      check({name, "_dt"}, req_mem_d_or_tag, dt);
    end
  endtask

  task automatic cfg(input logic [47:0] base, input logic [47:0] lim);
    drive(0, 0, 0, 0, 2'd0, 64'd0);
    cfg_st_base = base;
    cfg_st_end  = lim;
    cfg_wr      = 1'b1;
    @(posedge clk);
    #1;
    cfg_wr = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{0,0,0,0,2'd0,64'd0,          3'b000,0,0,48'h0,   64'h0};
    vecs[1]  = '{0,1,0,0,2'd0,64'd0,          3'b010,1,0,48'h2000,64'h1};
    vecs[2]  = '{0,0,1,0,2'd2,64'd0,          3'b001,1,0,48'h3000,64'h4};
    vecs[3]  = '{0,0,1,0,2'd1,64'd0,          3'b001,1,0,48'h3000,64'h2};
    vecs[4]  = '{0,1,1,0,2'd0,64'd0,          3'b010,1,0,48'h2000,64'h1};
    vecs[5]  = '{1,0,0,0,2'd0,64'hA5A5_0001,  3'b100,0,1,48'h100, 64'hA5A5_0001};
    vecs[6]  = '{1,1,1,0,2'd2,64'hB0B0_0002,  3'b100,0,1,48'h108, 64'hB0B0_0002};
    vecs[7]  = '{1,1,1,1,2'd0,64'hC0C0_0003,  3'b000,0,0,48'h0,   64'h0};
    vecs[8]  = '{1,1,0,1,2'd0,64'hC0C0_0003,  3'b000,0,0,48'h0,   64'h0};
    vecs[9]  = '{0,1,1,0,2'd0,64'd0,          3'b010,1,0,48'h2000,64'h1};
    vecs[10] = '{1,0,1,0,2'd3,64'hC0C0_0004,  3'b100,0,1,48'h110, 64'hC0C0_0004};
    vecs[11] = '{0,0,1,0,2'd3,64'd0,          3'b001,1,0,48'h3000,64'h6};
    vecs[12] = '{0,0,0,1,2'd0,64'd0,          3'b000,0,0,48'h0,   64'h0};

    rst         = 1'b1;
    cfg_wr      = 1'b0;
    cfg_st_base = '0;
    cfg_st_end  = '0;
    ldx_addr    = 48'h2000;
    ldm_addr    = 48'h3000;
    drive(0, 0, 0, 0, 2'd0, 64'd0);
    #1;
    check("rst_ld",   {63'b0, req_mem_ld}, 64'd0);
    check("rst_st",   {63'b0, req_mem_st}, 64'd0);
    check("rst_addr", {16'b0, req_mem_addr}, 64'd0);
    check("rst_dt",   req_mem_d_or_tag, 64'd0);
    check("rst_staddr", {16'b0, st_addr_q}, 64'd0);
    check("rst_done", {63'b0, st_window_done}, 64'd1);
    check("rst_busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-cycle arbitration vectors.
    cfg(48'h100, 48'h200);
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].s, vecs[i].x, vecs[i].m, vecs[i].stall, vecs[i].tag, vecs[i].d);
      tick_pop($sformatf("vec%0d_pop", i), vecs[i].pop);
      chk_req($sformatf("vec%0d", i), vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].dt);
    end

    // Store window: three stores issue, the fourth is dropped.
    cfg(48'h1000, 48'h1018);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 2'd0, 64'hD000 + 64'(i));
      tick_pop($sformatf("win%0d_pop", i), 3'b100);
      chk_req($sformatf("win%0d", i), 1'b0, (i < 3), 48'h1000 + 48'(8 * i), 64'hD000 + 64'(i));
    end
    check("win_done", {63'b0, st_window_done}, 64'd1);
    check("win_addr", {16'b0, st_addr_q}, 64'h1018);

    // Simultaneous requests issue in priority order on consecutive cycles.
    cfg(48'h5000, 48'h6000);
    drive(1, 1, 1, 0, 2'd2, 64'h5555);
    tick_pop("ord0_pop", 3'b100);
    chk_req("ord0", 1'b0, 1'b1, 48'h5000, 64'h5555);
    drive(0, 1, 1, 0, 2'd2, 64'd0);
    tick_pop("ord1_pop", 3'b010);
    chk_req("ord1", 1'b1, 1'b0, 48'h2000, 64'h1);
    drive(0, 0, 1, 0, 2'd2, 64'd0);
    tick_pop("ord2_pop", 3'b001);
    chk_req("ord2", 1'b1, 1'b0, 48'h3000, 64'h4);
    drive(0, 0, 0, 0, 2'd0, 64'd0);
    tick_pop("ord3_pop", 3'b000);
    chk_req("ord3", 1'b0, 1'b0, 48'h0, 64'h0);

    // Five stalled cycles: no pops, no strobes; resumes after stall drops.
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 1, 1, 2'd1, 64'h7777);
      tick_pop($sformatf("stall%0d_pop", i), 3'b000);
      chk_req($sformatf("stall%0d", i), 1'b0, 1'b0, 48'h0, 64'h0);
    end
    drive(1, 1, 1, 0, 2'd1, 64'h7777);
    tick_pop("resume_pop", 3'b100);
    chk_req("resume", 1'b0, 1'b1, 48'h5008, 64'h7777);
    drive(0, 0, 0, 0, 2'd0, 64'd0);
    tick_pop("idle_pop", 3'b000);

    // Continuous st + ldm: fairness grants ldm every 9th cycle, otherwise never.
    for (int k = 1; k <= 27; k++) begin
`ifdef SPMV_ARB_FAIRNESS_EN
      drive(1, 0, 1, 0, 2'd0, 64'h9);
      tick_pop($sformatf("fair%0d_pop", k), (k % 9 == 0) ? 3'b001 : 3'b100);
`else
      drive(1, 0, 1, 0, 2'd0, 64'h9);
      tick_pop($sformatf("fair%0d_pop", k), 3'b100);
`endif
    end
    drive(0, 0, 0, 0, 2'd0, 64'd0);
    tick_pop("idle2_pop", 3'b000);

    // Config write colliding with a store grant.
    cfg(48'h1000, 48'h2000);
    drive(1, 0, 0, 0, 2'd0, 64'hE0);
    tick_pop("cc0_pop", 3'b100);
    chk_req("cc0", 1'b0, 1'b1, 48'h1000, 64'hE0);
    drive(1, 0, 0, 0, 2'd0, 64'hE1);
    cfg_st_base = 48'h4000;
    cfg_st_end  = 48'h5000;
    cfg_wr      = 1'b1;
    tick_pop("cc1_pop", 3'b100);
    cfg_wr = 1'b0;
    chk_req("cc1", 1'b0, 1'b1, 48'h1008, 64'hE1);
    check("cc1_staddr", {16'b0, st_addr_q}, 64'h4000);
    drive(1, 0, 0, 0, 2'd0, 64'hE2);
    tick_pop("cc2_pop", 3'b100);
    chk_req("cc2", 1'b0, 1'b1, 48'h4000, 64'hE2);
    check("cc2_staddr", {16'b0, st_addr_q}, 64'h4008);

    // Asynchronous reset while a load strobe is on the port.
    drive(0, 1, 0, 0, 2'd0, 64'd0);
    tick_pop("ar_pop", 3'b010);
    check("ar_pre_ld", {63'b0, req_mem_ld}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_ld",     {63'b0, req_mem_ld}, 64'd0);
    check("ar_st",     {63'b0, req_mem_st}, 64'd0);
    check("ar_staddr", {16'b0, st_addr_q}, 64'd0);
    check("ar_done",   {63'b0, st_window_done}, 64'd1);
    check("ar_xpop",   {63'b0, ldx_pop}, 64'd0);
    check("ar_busy1",  {63'b0, busy}, 64'd1);
    ldx_valid = 1'b0;
    #1;
    check("ar_busy0",  {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1, 0, 0, 2'd0, 64'd0);
    tick_pop("post_pop", 3'b010);
    chk_req("post", 1'b1, 1'b0, 48'h2000, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
